// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM compare / dead-time leg: state and output-mode
// encodings plus the default widths of carrier, compare and dead-time count.
package pwm_pkg;

    localparam int PWM_WIDTH_DEF = 16;
    localparam int DT_WIDTH_DEF  = 8;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_HIGH = 2'b01,
        MODE_INV  = 2'b10,
        MODE_RSVD = 2'b11
    } out_mode_e;

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_DT_H = 3'd1,
        S_H_ON = 3'd2,
        S_DT_L = 3'd3,
        S_L_ON = 3'd4
    } dt_state_e;

    // Only the two defined drive modes enable the gates; reserved behaves as off.
    function automatic logic mode_is_on(input logic [1:0] mode);
        return (mode == MODE_HIGH) || (mode == MODE_INV);
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Gate-pair generator for one half-bridge leg: turns the registered reference
// into pwm_h/pwm_l. With PWM_DEADTIME_EN defined a break-before-make FSM is used.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DTWIDTH = DT_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               ref_in,
    input  logic               force_off,
    input  logic [DTWIDTH-1:0] deadtime,
    output logic               pwm_h,
    output logic               pwm_l
);

`ifdef PWM_DEADTIME_EN

    dt_state_e          state;
    logic [DTWIDTH-1:0] cnt;
    logic [DTWIDTH-1:0] dt_load;

    // The count reaches zero after max(deadtime,1) cycles, so deadtime=0 still
    // leaves a single-cycle gap between the two switches.
    assign dt_load = (deadtime == '0) ? '0 : deadtime - DTWIDTH'(1);

    // NOTE: outputs are decoded from the next state inside the same flop block,
    // so the gates come straight from registers and reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_OFF;
            cnt   <= '0;
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end else if (en) begin
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
            if (force_off) begin
                state <= S_OFF;
                cnt   <= '0;
            end else begin
                case (state)
                    S_OFF: begin
                        state <= ref_in ? S_DT_H : S_DT_L;
                        cnt   <= dt_load;
                    end
                    S_DT_H: begin
                        // A reference reversal aborts the gap; the high side never fired.
                        if (!ref_in) begin
                            state <= S_L_ON;
                            pwm_l <= 1'b1;
                        end else if (cnt == '0) begin
                            state <= S_H_ON;
                            pwm_h <= 1'b1;
                        end else begin
                            cnt <= cnt - DTWIDTH'(1);
                        end
                    end
                    S_H_ON: begin
                        if (!ref_in) begin
                            state <= S_DT_L;
                            cnt   <= dt_load;
                        end else begin
                            pwm_h <= 1'b1;
                        end
                    end
                    S_DT_L: begin
                        if (ref_in) begin
                            state <= S_H_ON;
                            pwm_h <= 1'b1;
                        end else if (cnt == '0) begin
                            state <= S_L_ON;
                            pwm_l <= 1'b1;
                        end else begin
                            cnt <= cnt - DTWIDTH'(1);
                        end
                    end
                    S_L_ON: begin
                        if (ref_in) begin
                            state <= S_DT_H;
                            cnt   <= dt_load;
                        end else begin
                            pwm_l <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_OFF;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`else

    // Direct complementary drive from the reference; the deadtime input is unused here.
    logic unused_deadtime;
    assign unused_deadtime = ^deadtime;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end else if (en) begin
            pwm_h <= !force_off && ref_in;
            pwm_l <= !force_off && !ref_in;
        end
    end

`endif

endmodule

// File: rtl/pwm_compare_16bits.sv
// PWM compare leg: double-buffered compare, carrier comparator and gate-pair
// output. Define PWM_DEADTIME_EN to build the dead-time FSM into the outputs.
module pwm_compare_16bits
    import pwm_pkg::*;
#(
    parameter int PWMWIDTH = PWM_WIDTH_DEF,
    parameter int DTWIDTH  = DT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic [PWMWIDTH-1:0] carrier,
    input  logic                sync,
    input  logic [PWMWIDTH-1:0] compare,
    input  logic [DTWIDTH-1:0]  deadtime,
    input  logic [1:0]          out_mode,
    output logic                pwm_h,
    output logic                pwm_l,
    output logic [PWMWIDTH-1:0] cmp_active
);

    logic ref_d;
    logic ref_q;
    logic force_off;

    assign force_off = !mode_is_on(out_mode);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ref_d = 1'b0;
        case (out_mode)
            MODE_HIGH: ref_d = (carrier <  cmp_active);
            MODE_INV:  ref_d = (carrier >= cmp_active);
            default:   ref_d = 1'b0;
        endcase
    end

    // Shadow load only on sync keeps a duty update from tearing a running period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_active <= '0;
            ref_q      <= 1'b0;
        end else if (ce) begin
            if (sync) begin
                cmp_active <= compare;
            end
            ref_q <= ref_d;
        end
    end

    pwm_deadtime #(
        .DTWIDTH (DTWIDTH)
    ) u_deadtime (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (ce),
        .ref_in    (ref_q),
        .force_off (force_off),
        .deadtime  (deadtime),
        .pwm_h     (pwm_h),
        .pwm_l     (pwm_l)
    );

endmodule
